// File: rtl/cntr8_ctrl_if.sv
// Control/status bundle for the cntr8 counter: load/count controls in,
// registered count, state code and terminal-count pulse out.
interface cntr8_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic             en;
    logic             inc;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [2:0]       o_state;
    logic             tc;

    modport master (
        output load, en, inc, d_in,
        input  d_out, o_state, tc
    );

    modport slave (
        input  load, en, inc, d_in,
        output d_out, o_state, tc
    );
endinterface

// File: rtl/cntr8_ctrl.sv
// Loadable up/down counter whose FSM selects load/hold/+1/-1 and whose
// arithmetic comes from a ripple of 4-bit carry-look-ahead slices.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

module cntr8_ctrl #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    cntr8_ctrl_if.slave  bus
);
    localparam int NSL = WIDTH / 4;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             tc, tc_nxt;
    logic             up_nxt, dn_nxt;

    logic [NSL-1:0][3:0] a_vec, b_vec, s_vec;
    logic [NSL:0]        carry;

    // Operand selection is driven by the next state so the sum is ready for this edge.
    assign up_nxt   = (state_nxt == INC) || (state_nxt == INC2);
    assign dn_nxt   = (state_nxt == DEC) || (state_nxt == DEC2);
    assign a_vec    = cnt;
    assign b_vec    = dn_nxt ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign carry[0] = ~dn_nxt;

    for (genvar k = 0; k < NSL; k++) begin : g_slice
        cla4 u_cla4 (
            .a  (a_vec[k]),
            .b  (b_vec[k]),
            .ci (carry[k]),
            .s  (s_vec[k]),
            .co (carry[k+1])
        );
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, LOAD, INC, INC2, DEC, DEC2: begin
                if (bus.load)     state_nxt = LOAD;
                else if (!bus.en) state_nxt = IDLE;
                else if (bus.inc) state_nxt = (state == INC) ? INC2 : INC;
                else              state_nxt = (state == DEC) ? DEC2 : DEC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final carry flags wrap: set on all-ones +1, clear on 0 + all-ones.
    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        if (state_nxt == LOAD) begin
            cnt_nxt = bus.d_in;
        end else if (up_nxt) begin
            cnt_nxt = s_vec;
            tc_nxt  = carry[NSL];
        end else if (dn_nxt) begin
            cnt_nxt = s_vec;
            tc_nxt  = ~carry[NSL];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tc    <= tc_nxt;
        end
    end

    assign bus.d_out   = cnt;
    assign bus.o_state = state;
    assign bus.tc      = tc;
endmodule

// File: tb/tb_cntr8_ctrl.sv
// Directed-vector bench for cntr8_ctrl: reset, count, wrap, load priority,
// direction change and mid-count reset.
module tb_cntr8_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cntr8_ctrl_if #(.WIDTH(8)) bus ();

    cntr8_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic e, input logic i, input logic [7:0] d);
        bus.load = ld;
        bus.en   = e;
        bus.inc  = i;
        bus.d_in = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hA5);
        tick();
        tick();
        n_checks++;
        if (bus.d_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_d_out got %h want 00", bus.d_out);
        end
        n_checks++;
        if (bus.o_state !== 3'b000) begin
            n_fail++; $display("FAIL reset_state got %b want 000", bus.o_state);
        end
        n_checks++;
        if (bus.tc !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc got %b want 0", bus.tc);
        end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] ed [4] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
        logic [2:0] es [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 8'h3C);
            else        drive(1'b0, 1'b1, 1'b1, 8'h00);
            tick();
            n_checks++;
            if ({bus.d_out, bus.o_state, bus.tc} !== {ed[k], es[k], 1'b0}) begin
                n_fail++;
                $display("FAIL count_up[%0d] got d=%h s=%b tc=%b want d=%h s=%b tc=0",
                         k, bus.d_out, bus.o_state, bus.tc, ed[k], es[k]);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [7:0] ed [4] = '{8'hFE, 8'hFF, 8'h00, 8'h00};
        logic [2:0] es [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
        logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 1'b0, 8'hFE);
            else if (k < 3)  drive(1'b0, 1'b1, 1'b1, 8'h00);
            else             drive(1'b0, 1'b0, 1'b1, 8'h00);
            tick();
            n_checks++;
            if ({bus.d_out, bus.o_state, bus.tc} !== {ed[k], es[k], et[k]}) begin
                n_fail++;
                $display("FAIL wrap_up[%0d] got d=%h s=%b tc=%b want d=%h s=%b tc=%b",
                         k, bus.d_out, bus.o_state, bus.tc, ed[k], es[k], et[k]);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [7:0] ed [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
        logic [2:0] es [4] = '{3'b001, 3'b100, 3'b101, 3'b100};
        logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 8'h01);
            else        drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            n_checks++;
            if ({bus.d_out, bus.o_state, bus.tc} !== {ed[k], es[k], et[k]}) begin
                n_fail++;
                $display("FAIL wrap_down[%0d] got d=%h s=%b tc=%b want d=%h s=%b tc=%b",
                         k, bus.d_out, bus.o_state, bus.tc, ed[k], es[k], et[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1'b1, 1'b0, 1'b0, 8'h0F); tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00); tick();
        n_checks++;
        if ({bus.d_out, bus.o_state} !== {8'h10, 3'b010}) begin
            n_fail++; $display("FAIL lp_pre got d=%h s=%b want d=10 s=010", bus.d_out, bus.o_state);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77); tick();
        n_checks++;
        if ({bus.d_out, bus.o_state, bus.tc} !== {8'h77, 3'b001, 1'b0}) begin
            n_fail++;
            $display("FAIL lp_load got d=%h s=%b tc=%b want d=77 s=001 tc=0",
                     bus.d_out, bus.o_state, bus.tc);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        n_checks++;
        if ({bus.d_out, bus.o_state} !== {8'h77, 3'b000}) begin
            n_fail++; $display("FAIL lp_hold got d=%h s=%b want d=77 s=000", bus.d_out, bus.o_state);
        end
        // Loading all-ones must not raise tc.
        drive(1'b1, 1'b0, 1'b0, 8'hFF); tick();
        n_checks++;
        if ({bus.d_out, bus.tc} !== {8'hFF, 1'b0}) begin
            n_fail++; $display("FAIL lp_ff got d=%h tc=%b want d=ff tc=0", bus.d_out, bus.tc);
        end
    endtask

    task automatic test_dir_change();
        logic       di [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] ed [5] = '{8'h21, 8'h22, 8'h21, 8'h20, 8'h21};
        logic [2:0] es [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b010};
        drive(1'b1, 1'b0, 1'b0, 8'h20); tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, di[k], 8'h00);
            tick();
            n_checks++;
            if ({bus.d_out, bus.o_state, bus.tc} !== {ed[k], es[k], 1'b0}) begin
                n_fail++;
                $display("FAIL dir_change[%0d] got d=%h s=%b tc=%b want d=%h s=%b tc=0",
                         k, bus.d_out, bus.o_state, bus.tc, ed[k], es[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 8'h51); tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
        n_checks++;
        if ({bus.d_out, bus.o_state} !== {8'h50, 3'b100}) begin
            n_fail++; $display("FAIL rm_pre got d=%h s=%b want d=50 s=100", bus.d_out, bus.o_state);
        end
        reset = 1'b1; tick();
        n_checks++;
        if ({bus.d_out, bus.o_state, bus.tc} !== {8'h00, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL rm_reset got d=%h s=%b tc=%b want d=00 s=000 tc=0",
                     bus.d_out, bus.o_state, bus.tc);
        end
        reset = 1'b0; tick();
        n_checks++;
        if ({bus.d_out, bus.o_state, bus.tc} !== {8'hFF, 3'b100, 1'b1}) begin
            n_fail++;
            $display("FAIL rm_release got d=%h s=%b tc=%b want d=ff s=100 tc=1",
                     bus.d_out, bus.o_state, bus.tc);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_dir_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
